// File: rtl/serial_subtractor16.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one result per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset
//   start_i     launch request, sampled on rising clk_i
//   a_i, b_i    minuend / subtrahend, captured when start is accepted
//   bin_i       borrow-in, captured when start is accepted
//   busy_o      high while bits are being computed
//   done_o      one-cycle pulse when diff_o/bout_o/overflow_o update
//   diff_o      a - b - bin modulo 2^WIDTH, held until the next done
//   bout_o      unsigned borrow-out
//   overflow_o  signed overflow of the subtraction
module serial_subtractor16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Holds the WIDTH-1 low result bits; the last bit joins them on the done edge.
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  // Full-subtractor slice on the current LSBs.
  logic d_bit;
  logic br_d;
  logic last_bit;

  assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= (WIDTH-1)'({d_bit, res_q} >> 1);
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            // Outputs load together from the final slice; overflow compares
            // the borrow into the MSB with the borrow out of it.
            diff_q  <= {d_bit, res_q};
            bout_q  <= br_d;
            ovf_q   <= br_q ^ br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; DONE lasts one cycle.
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            br_q    <= bin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign diff_o     = diff_q;
  assign bout_o     = bout_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_subtractor16.sv
// Testbench for serial_subtractor16: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_serial_subtractor16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        bin_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] diff_o;
  logic        bout_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor16 #(.WIDTH(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .bin_i      (bin_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .diff_o     (diff_o),
    .bout_o     (bout_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int ua, ub, sa, sb, r;
    logic [15:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = 16'((ua - ub - int'(bin)) & 32'hFFFF);
    bo = (ua < ub + int'(bin));
    r  = sa - sb - int'(bin);
    ov = (r < -32768) || (r > 32767);
    return {ov, bo, d};
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bin);
    a_i = a; b_i = b; bin_i = bin; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = 16'($urandom); b_i = 16'($urandom); bin_i = 1'($urandom);
  endtask

  // Waits for done (bounded), checks busy length, output hold and the result.
  // poke >= 0 pulses a second start that many cycles into the operation.
  task automatic wait_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic bin, input int poke);
    logic [17:0] exp, prev;
    int n, busy_cnt, hold_bad, overlap;
    exp = model(a, b, bin);
    prev = {overflow_o, bout_o, diff_o};
    n = 0; busy_cnt = 0; hold_bad = 0; overlap = 0;
    while (!done_o && n < 40) begin
      if (busy_o) busy_cnt++;
      if ({overflow_o, bout_o, diff_o} !== prev) hold_bad++;
      if (n == poke) begin
        a_i = 16'h0001; b_i = 16'h0001; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
        a_i = 16'($urandom); b_i = 16'($urandom); bin_i = 1'($urandom);
      end
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b0;
    if (busy_o && done_o) overlap = 1;
    chk({tag, "_done_seen"}, 32'(done_o), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd16);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
    chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_diff"}, 32'(diff_o), 32'(exp[15:0]));
    chk({tag, "_bout"}, 32'(bout_o), 32'(exp[16]));
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(exp[17]));
  endtask

  // Full single operation followed by a check that done was a single pulse.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin);
    logic [17:0] exp;
    exp = model(a, b, bin);
    launch(a, b, bin);
    wait_result(tag, a, b, bin, -1);
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, 32'({done_o, busy_o}), 32'd0);
    chk({tag, "_held"}, 32'({overflow_o, bout_o, diff_o}), 32'(exp));
  endtask

  initial begin
    int done_cnt;
    logic [15:0] ra, rb;
    logic rbin;

    #2;
    chk("reset_outputs", 32'({busy_o, done_o, bout_o, overflow_o, diff_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after_reset", 32'({busy_o, done_o, diff_o}), 32'd0);

    run_op("t1_5m3", 16'h0005, 16'h0003, 1'b0);
    run_op("t2_0m1", 16'h0000, 16'h0001, 1'b0);
    run_op("t2_eq_bin", 16'h1234, 16'h1234, 1'b1);
    run_op("t3_neg_ovf", 16'h8000, 16'h0001, 1'b0);
    run_op("t3_pos_ovf", 16'h7FFF, 16'hFFFF, 1'b0);

    // Start while busy is ignored.
    launch(16'hAAAA, 16'h5555, 1'b0);
    wait_result("t4_ignore", 16'hAAAA, 16'h5555, 1'b0, 4);
    @(negedge clk_i);
    chk("t4_no_restart", 32'({done_o, busy_o}), 32'd0);

    // Back-to-back: start during the done cycle.
    launch(16'h3000, 16'h0123, 1'b0);
    wait_result("t5_first", 16'h3000, 16'h0123, 1'b0, -1);
    launch(16'h0010, 16'h0001, 1'b0);
    chk("t5_busy_after_done", 32'({busy_o, done_o}), 32'b10);
    wait_result("t5_second", 16'h0010, 16'h0001, 1'b0, -1);
    @(negedge clk_i);

    // Asynchronous reset in the middle of an operation.
    launch(16'h4321, 16'h1234, 1'b0);
    repeat (7) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_async_clear", 32'({busy_o, done_o, bout_o, overflow_o, diff_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) done_cnt++;
    end
    chk("t6_no_done_after_abort", 32'(done_cnt), 32'd0);
    run_op("t6_recover", 16'h4321, 16'h1234, 1'b0);

    // Random operations, some back-to-back.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 3 == 0) begin
        ra[15] = 1'b0; rb[15] = 1'b1;
      end
      launch(ra, rb, rbin);
      wait_result("rand", ra, rb, rbin, (i % 4 == 1) ? int'($urandom_range(0, 12)) : -1);
      if (i % 5 != 2) @(negedge clk_i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
